ptw_mem_responder: RTL and testbench

//  Memory-side responder for the page-table walker's PTE-read and PTE-mark interfaces.

---
 rtl/ptw_rsp_pkg.sv | 32 +++
 rtl/pte_mark_merge.sv | 38 +++
 rtl/ptw_mem_responder.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_ptw_mem_responder.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ptw_rsp_pkg.sv
// Shared definitions for the page-table-walker memory responder.
//   state_t       : responder FSM states (also exported on the debug port)
//   PTE_V/A/D     : PTE bit positions (valid, accessed, dirty)
//   LINE_W/PTE_W  : L2 line width and PTE width; a line holds two PTEs
//   LINE_SEL_BIT  : byte-address bit that picks the PTE half of a line
//   line_half()   : extracts the addressed PTE from a line
package ptw_rsp_pkg;

   localparam int DEF_PA_W     = 32;
   localparam int LINE_W       = 128;
   localparam int PTE_W        = 64;
   localparam int PTE_V        = 0;
   localparam int PTE_A        = 6;
   localparam int PTE_D        = 7;
   localparam int LINE_SEL_BIT = 3;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      RD_REQ     = 3'd1,
      RD_WAIT    = 3'd2,
      MK_RD_REQ  = 3'd3,
      MK_RD_WAIT = 3'd4,
      MK_WR_REQ  = 3'd5,
      MK_WR_WAIT = 3'd6
   } state_t;

   function automatic logic [PTE_W-1:0] line_half(input logic [LINE_W-1:0] line,
                                                   input logic              sel);
      return sel ? line[LINE_W-1:PTE_W] : line[PTE_W-1:0];
   endfunction

endpackage

// File: rtl/pte_mark_merge.sv
// Combinational accessed/dirty merge into one PTE of a 128b line.
//   line_in  : line as read from L2 (or the forwarding buffer)
//   sel      : 0 = low PTE, 1 = high PTE
//   set_a    : set the A bit
//   set_d    : set the D bit (implies A)
//   line_out : merged line; the other PTE and all other bits pass through
//   changed  : merged line differs from line_in, i.e. a write-back is needed
module pte_mark_merge
   import ptw_rsp_pkg::*;
(
   input  logic [LINE_W-1:0] line_in,
   input  logic              sel,
   input  logic              set_a,
   input  logic              set_d,
   output logic [LINE_W-1:0] line_out,
   output logic              changed
);

   logic [PTE_W-1:0] pte_lo;
   logic [PTE_W-1:0] pte_hi;
   logic [PTE_W-1:0] mask;

   always_comb begin
      mask        = '0;
      mask[PTE_A] = set_a | set_d;
      mask[PTE_D] = set_d;
      pte_lo      = line_in[PTE_W-1:0];
      pte_hi      = line_in[LINE_W-1:PTE_W];
      if (sel) begin
         pte_hi = pte_hi | mask;
      end else begin
         pte_lo = pte_lo | mask;
      end
      line_out = {pte_hi, pte_lo};
      changed  = (line_out != line_in);
   end

endmodule

// File: rtl/ptw_mem_responder.sv
// Memory-side responder for the page-table walker.
// Serves single-cycle PTE read pulses (returns the PTE and its whole line)
// and accessed/dirty mark pulses (read-modify-write of the PTE, write skipped
// when the bits are already set). One L2 transaction is in flight at a time.
//
// Ports
//   clk, reset            clock; asynchronous active-low reset
//   mem_req_*             PTE read pulse, address, store flag (must be 0)
//   mem_rsp_*             read response pulse, selected PTE, full line
//   mem_mark_*            mark pulse, A/D flags, 64b address (low PA_W used)
//   mem_mark_rsp_valid    mark completion pulse
//   l2_req_*              L2 request channel (valid/ready)
//   l2_rsp_*              L2 read data / write ack pulse
//   dbg_state             current FSM state
//
// Build option: PTW_PTE_FWD_EN adds a one-entry buffer holding the last
// written line; reads and marks that hit it do not read L2.
//
// L2 request handshake: l2_req_valid, l2_req_store, l2_req_addr and
// l2_req_data are held stable from the cycle valid rises until the cycle in
// which l2_req_ready is also high; the request transfers in that cycle.
// Exactly one l2_rsp_valid pulse follows each transferred request.
module ptw_mem_responder
   import ptw_rsp_pkg::*;
#(
   parameter int PA_W = DEF_PA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mem_req_valid,
   input  logic [PA_W-1:0]   mem_req_addr,
   input  logic              mem_req_store,
   output logic              mem_rsp_valid,
   output logic [PTE_W-1:0]  mem_rsp_data,
   output logic [LINE_W-1:0] mem_rsp_cacheline,
   input  logic              mem_mark_valid,
   input  logic              mem_mark_accessed,
   input  logic              mem_mark_dirty,
   input  logic [63:0]       mem_mark_addr,
   output logic              mem_mark_rsp_valid,
   output logic              l2_req_valid,
   input  logic              l2_req_ready,
   output logic              l2_req_store,
   output logic [PA_W-1:0]   l2_req_addr,
   output logic [LINE_W-1:0] l2_req_data,
   input  logic              l2_rsp_valid,
   input  logic [LINE_W-1:0] l2_rsp_data,
   output state_t            dbg_state
);

   state_t            state;
   state_t            state_n;

   // Requests that arrive while the FSM is busy wait here.
   logic              pend_rd;
   logic [PA_W-1:0]   rd_addr_q;
   logic              pend_mk;
   logic [PA_W-1:0]   mk_addr_q;
   logic              mk_a_q;
   logic              mk_d_q;

   // Operation currently owned by the FSM.
   logic [PA_W-1:0]   op_addr;
   logic              op_a;
   logic              op_d;
   logic              op_hit;
   logic [LINE_W-1:0] wr_line;

   logic              rd_avail;
   logic              mk_avail;
   logic              take_rd;
   logic              take_mk;
   logic [PA_W-1:0]   rd_src_addr;
   logic [PA_W-1:0]   mk_src_addr;
   logic              mk_src_a;
   logic              mk_src_d;
   logic              rd_src_hit;
   logic              mk_src_hit;
   logic [LINE_W-1:0] src_line;
   logic [LINE_W-1:0] merged_line;
   logic              merge_changed;
   logic              rd_done;
   logic              mk_done;
   logic              load_wr;

   // A pulse arriving in IDLE is taken directly so the L2 request goes out
   // the very next cycle; otherwise the pending copy is used.
   assign rd_avail    = pend_rd | mem_req_valid;
   assign mk_avail    = pend_mk | mem_mark_valid;
   assign rd_src_addr = pend_rd ? rd_addr_q : mem_req_addr;
   assign mk_src_addr = pend_mk ? mk_addr_q : mem_mark_addr[PA_W-1:0];
   assign mk_src_a    = pend_mk ? mk_a_q : mem_mark_accessed;
   assign mk_src_d    = pend_mk ? mk_d_q : mem_mark_dirty;
   assign take_rd     = (state == IDLE) && rd_avail;
   assign take_mk     = (state == IDLE) && !rd_avail && mk_avail;

`ifdef PTW_PTE_FWD_EN
   logic              fwd_valid;
   logic [PA_W-1:0]   fwd_addr;
   logic [LINE_W-1:0] fwd_line;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fwd_valid <= 1'b0;
         fwd_addr  <= '0;
         fwd_line  <= '0;
      end else if (load_wr) begin
         fwd_valid <= 1'b1;
         fwd_addr  <= {op_addr[PA_W-1:4], 4'h0};
         fwd_line  <= merged_line;
      end
   end

   assign rd_src_hit = fwd_valid && ({rd_src_addr[PA_W-1:4], 4'h0} == fwd_addr);
   assign mk_src_hit = fwd_valid && ({mk_src_addr[PA_W-1:4], 4'h0} == fwd_addr);
   assign src_line   = op_hit ? fwd_line : l2_rsp_data;
`else
   assign rd_src_hit = 1'b0;
   assign mk_src_hit = 1'b0;
   assign src_line   = l2_rsp_data;
`endif

   pte_mark_merge u_merge (
      .line_in  (src_line),
      .sel      (op_addr[LINE_SEL_BIT]),
      .set_a    (op_a),
      .set_d    (op_d),
      .line_out (merged_line),
      .changed  (merge_changed)
   );

   always_comb begin
      state_n      = state;
      l2_req_valid = 1'b0;
      l2_req_store = 1'b0;
      rd_done      = 1'b0;
      mk_done      = 1'b0;
      load_wr      = 1'b0;
      case (state)
         IDLE: begin
            if (take_rd) begin
               state_n = RD_REQ;
            end else if (take_mk) begin
               state_n = MK_RD_REQ;
            end
         end
         RD_REQ: begin
            if (op_hit) begin
               rd_done = 1'b1;
               state_n = IDLE;
            end else begin
               l2_req_valid = 1'b1;
               if (l2_req_ready) state_n = RD_WAIT;
            end
         end
         RD_WAIT: begin
            if (l2_rsp_valid) begin
               rd_done = 1'b1;
               state_n = IDLE;
            end
         end
         MK_RD_REQ: begin
            if (op_hit) begin
               // Buffer hit: merge immediately, same decision as after a read.
               if (merge_changed) begin
                  load_wr = 1'b1;
                  state_n = MK_WR_REQ;
               end else begin
                  mk_done = 1'b1;
                  state_n = IDLE;
               end
            end else begin
               l2_req_valid = 1'b1;
               if (l2_req_ready) state_n = MK_RD_WAIT;
            end
         end
         MK_RD_WAIT: begin
            if (l2_rsp_valid) begin
               if (merge_changed) begin
                  load_wr = 1'b1;
                  state_n = MK_WR_REQ;
               end else begin
                  mk_done = 1'b1;
                  state_n = IDLE;
               end
            end
         end
         MK_WR_REQ: begin
            l2_req_valid = 1'b1;
            l2_req_store = 1'b1;
            if (l2_req_ready) state_n = MK_WR_WAIT;
         end
         MK_WR_WAIT: begin
            if (l2_rsp_valid) begin
               mk_done = 1'b1;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state              <= IDLE;
         pend_rd            <= 1'b0;
         rd_addr_q          <= '0;
         pend_mk            <= 1'b0;
         mk_addr_q          <= '0;
         mk_a_q             <= 1'b0;
         mk_d_q             <= 1'b0;
         op_addr            <= '0;
         op_a               <= 1'b0;
         op_d               <= 1'b0;
         op_hit             <= 1'b0;
         wr_line            <= '0;
         mem_rsp_valid      <= 1'b0;
         mem_rsp_data       <= '0;
         mem_rsp_cacheline  <= '0;
         mem_mark_rsp_valid <= 1'b0;
      end else begin
         state <= state_n;

         // A pulse while the same type is already pending is dropped.
         if (take_rd) begin
            pend_rd <= 1'b0;
         end else if (mem_req_valid && !pend_rd) begin
            pend_rd   <= 1'b1;
            rd_addr_q <= mem_req_addr;
         end

         if (take_mk) begin
            pend_mk <= 1'b0;
         end else if (mem_mark_valid && !pend_mk) begin
            pend_mk   <= 1'b1;
            mk_addr_q <= mem_mark_addr[PA_W-1:0];
            mk_a_q    <= mem_mark_accessed;
            mk_d_q    <= mem_mark_dirty;
         end

         if (take_rd) begin
            op_addr <= rd_src_addr;
            op_a    <= 1'b0;
            op_d    <= 1'b0;
            op_hit  <= rd_src_hit;
         end else if (take_mk) begin
            op_addr <= mk_src_addr;
            op_a    <= mk_src_a;
            op_d    <= mk_src_d;
            op_hit  <= mk_src_hit;
         end

         if (load_wr) wr_line <= merged_line;

         mem_rsp_valid      <= rd_done;
         mem_mark_rsp_valid <= mk_done;
         if (rd_done) begin
            mem_rsp_cacheline <= src_line;
            mem_rsp_data      <= line_half(src_line, op_addr[LINE_SEL_BIT]);
         end
      end
   end

   assign l2_req_addr = {op_addr[PA_W-1:4], 4'h0};
   assign l2_req_data = wr_line;
   assign dbg_state   = state;

   logic unused_bits;
   assign unused_bits = ^{mem_mark_addr[63:PA_W], op_addr[2:0], mem_req_store};

   a_no_store: assert property (@(posedge clk) disable iff (!reset)
      mem_req_valid |-> !mem_req_store);
   a_rd_dup: assert property (@(posedge clk) disable iff (!reset)
      !(mem_req_valid && pend_rd));
   a_mk_dup: assert property (@(posedge clk) disable iff (!reset)
      !(mem_mark_valid && pend_mk));
   a_rsp_in_wait: assert property (@(posedge clk) disable iff (!reset)
      l2_rsp_valid |-> (state == RD_WAIT || state == MK_RD_WAIT || state == MK_WR_WAIT));

endmodule

// File: tb/tb_ptw_mem_responder.sv
module tb_ptw_mem_responder;
   import ptw_rsp_pkg::*;

   localparam int PA_W = DEF_PA_W;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   int cycle = 0;
   always @(posedge clk) cycle <= cycle + 1;

   logic              mem_req_valid = 1'b0;
   logic [PA_W-1:0]   mem_req_addr = '0;
   logic              mem_req_store = 1'b0;
   logic              mem_rsp_valid;
   logic [63:0]       mem_rsp_data;
   logic [127:0]      mem_rsp_cacheline;
   logic              mem_mark_valid = 1'b0;
   logic              mem_mark_accessed = 1'b0;
   logic              mem_mark_dirty = 1'b0;
   logic [63:0]       mem_mark_addr = '0;
   logic              mem_mark_rsp_valid;
   logic              l2_req_valid;
   logic              l2_req_ready;
   logic              l2_req_store;
   logic [PA_W-1:0]   l2_req_addr;
   logic [127:0]      l2_req_data;
   logic              l2_rsp_valid;
   logic [127:0]      l2_rsp_data;
   state_t            dbg_state;

   ptw_mem_responder #(.PA_W(PA_W)) dut (
      .clk                (clk),
      .reset              (reset),
      .mem_req_valid      (mem_req_valid),
      .mem_req_addr       (mem_req_addr),
      .mem_req_store      (mem_req_store),
      .mem_rsp_valid      (mem_rsp_valid),
      .mem_rsp_data       (mem_rsp_data),
      .mem_rsp_cacheline  (mem_rsp_cacheline),
      .mem_mark_valid     (mem_mark_valid),
      .mem_mark_accessed  (mem_mark_accessed),
      .mem_mark_dirty     (mem_mark_dirty),
      .mem_mark_addr      (mem_mark_addr),
      .mem_mark_rsp_valid (mem_mark_rsp_valid),
      .l2_req_valid       (l2_req_valid),
      .l2_req_ready       (l2_req_ready),
      .l2_req_store       (l2_req_store),
      .l2_req_addr        (l2_req_addr),
      .l2_req_data        (l2_req_data),
      .l2_rsp_valid       (l2_rsp_valid),
      .l2_rsp_data        (l2_rsp_data),
      .dbg_state          (dbg_state)
   );

   // ---------------- checking bookkeeping ----------------
   int n_checks = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
   endtask

   // ---------------- reference model (PTE-granular memory) ----------------
   logic [63:0]  ref_pte [logic [31:0]];
   logic [127:0] l2_mem  [logic [31:0]];

   logic [191:0] exp_rd_q[$];   // {pte, line}
   logic [0:0]   exp_mk_q[$];
   logic [159:0] exp_wr_q[$];   // {line address, line}

   function automatic logic [63:0] ref_get(input logic [31:0] a);
      return ref_pte.exists(a) ? ref_pte[a] : 64'h0;
   endfunction

   function automatic logic [127:0] ref_line(input logic [31:0] a);
      logic [31:0] la;
      la = a & 32'hFFFF_FFF0;
      return {ref_get(la + 32'h8), ref_get(la)};
   endfunction

   task automatic set_line(input logic [31:0] la, input logic [127:0] line);
      l2_mem[la]          = line;
      ref_pte[la]         = line[63:0];
      ref_pte[la + 32'h8] = line[127:64];
   endtask

   task automatic model_read(input logic [31:0] a);
      exp_rd_q.push_back({ref_get(a & 32'hFFFF_FFF8), ref_line(a)});
   endtask

   task automatic model_mark(input logic [31:0] a, input bit acc, input bit dty);
      logic [31:0] pa;
      logic [63:0] old_v;
      logic [63:0] new_v;
      pa    = a & 32'hFFFF_FFF8;
      old_v = ref_get(pa);
      new_v = old_v | (dty ? 64'hC0 : (acc ? 64'h40 : 64'h0));
      if (new_v != old_v) begin
         ref_pte[pa] = new_v;
         exp_wr_q.push_back({a & 32'hFFFF_FFF0, ref_line(a)});
      end
      exp_mk_q.push_back(1'b1);
   endtask

   // ---------------- L2 model ----------------
   bit hold_store = 0;
   int lat_force = 0;
   int n_l2_reads = 0;
   int n_l2_writes = 0;
   int last_l2_rsp_cycle = 0;

   initial begin
      l2_req_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         l2_req_ready = (hold_store && l2_req_store) ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
   end

   initial begin
      logic        st;
      logic [31:0] a;
      logic [127:0] d;
      logic [159:0] w;
      int          lat;
      bit          aborted;
      l2_rsp_valid = 1'b0;
      l2_rsp_data  = '0;
      forever begin
         @(negedge clk);
         if (reset && l2_req_valid && l2_req_ready) begin
            st = l2_req_store;
            a  = l2_req_addr;
            d  = l2_req_data;
            if (st) begin
               n_l2_writes++;
               if (exp_wr_q.size() == 0) begin
                  n_checks++;
                  $display("FAIL l2_unexpected_write: addr 0x%0h data 0x%0h, expected no write", a, d);
               end else begin
                  w = exp_wr_q.pop_front();
                  chk("l2_wr_addr", 128'(a), 128'(w[159:128]));
                  chk("l2_wr_data", d, w[127:0]);
               end
               l2_mem[a] = d;
            end else begin
               n_l2_reads++;
            end
            @(posedge clk);
            lat = (lat_force != 0) ? lat_force : $urandom_range(0, 3);
            aborted = !reset;
            for (int i = 0; i < lat && !aborted; i++) begin
               @(posedge clk);
               if (!reset) aborted = 1;
            end
            if (!aborted && reset) begin
               #1;
               l2_rsp_valid = 1'b1;
               l2_rsp_data  = st ? {$urandom(), $urandom(), $urandom(), $urandom()}
                                 : (l2_mem.exists(a) ? l2_mem[a] : 128'h0);
               last_l2_rsp_cycle = cycle;
               @(posedge clk);
               #1;
               l2_rsp_valid = 1'b0;
            end
         end
      end
   end

   // ---------------- monitor / scoreboard ----------------
   int last_rsp_cycle = 0;
   int last_mk_cycle = 0;
   logic [63:0] last_rsp_data = '0;

   initial begin
      logic [191:0] e;
      forever begin
         @(negedge clk);
         if (reset && mem_rsp_valid) begin
            last_rsp_cycle = cycle;
            last_rsp_data  = mem_rsp_data;
            if (exp_rd_q.size() == 0) begin
               n_checks++;
               $display("FAIL rsp_unexpected: got data 0x%0h, expected no response", mem_rsp_data);
            end else begin
               e = exp_rd_q.pop_front();
               chk("rsp_data", 128'(mem_rsp_data), 128'(e[191:128]));
               chk("rsp_line", mem_rsp_cacheline, e[127:0]);
`ifndef PTW_PTE_FWD_EN
               chk("rsp_latency", 128'(cycle - last_l2_rsp_cycle), 128'(1));
`endif
            end
         end
         if (reset && mem_mark_rsp_valid) begin
            last_mk_cycle = cycle;
            if (exp_mk_q.size() == 0) begin
               n_checks++;
               $display("FAIL mark_rsp_unexpected: got pulse, expected none");
            end else begin
               void'(exp_mk_q.pop_front());
               n_checks++;
               n_pass++;
`ifndef PTW_PTE_FWD_EN
               chk("mark_latency", 128'(cycle - last_l2_rsp_cycle), 128'(1));
`endif
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive(input bit do_rd, input logic [31:0] ra,
                        input bit do_mk, input logic [31:0] ma, input bit acc, input bit dty);
      @(posedge clk);
      #1;
      if (do_rd) begin
         model_read(ra);
         mem_req_valid = 1'b1;
         mem_req_addr  = ra;
      end
      if (do_mk) begin
         model_mark(ma, acc, dty);
         mem_mark_valid    = 1'b1;
         mem_mark_addr     = {$urandom(), ma};
         mem_mark_accessed = acc;
         mem_mark_dirty    = dty;
      end
      @(posedge clk);
      #1;
      mem_req_valid     = 1'b0;
      mem_mark_valid    = 1'b0;
      mem_req_addr      = $urandom();
      mem_mark_addr     = {$urandom(), $urandom()};
      mem_mark_accessed = 1'($urandom_range(0, 1));
      mem_mark_dirty    = 1'($urandom_range(0, 1));
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while ((exp_rd_q.size() != 0 || exp_mk_q.size() != 0) && n < budget) begin
         @(posedge clk);
         n++;
      end
      if (n >= budget) begin
         n_checks++;
         $display("FAIL timeout: %0d read / %0d mark responses outstanding after %0d cycles",
                  exp_rd_q.size(), exp_mk_q.size(), n);
         exp_rd_q.delete();
         exp_mk_q.delete();
      end
      repeat (2) @(posedge clk);
      chk("writes_drained", 128'(exp_wr_q.size()), 128'(0));
      exp_wr_q.delete();
   endtask

   task automatic check_outputs_zero(input string tag);
      chk({tag, "_rsp_valid"}, 128'(mem_rsp_valid), 128'(0));
      chk({tag, "_rsp_data"}, 128'(mem_rsp_data), 128'(0));
      chk({tag, "_rsp_line"}, mem_rsp_cacheline, 128'(0));
      chk({tag, "_mark_rsp"}, 128'(mem_mark_rsp_valid), 128'(0));
      chk({tag, "_l2_valid_store"}, 128'({l2_req_valid, l2_req_store}), 128'(0));
      chk({tag, "_l2_addr"}, 128'(l2_req_addr), 128'(0));
      chk({tag, "_l2_data"}, l2_req_data, 128'(0));
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int n;
      int w0;
      logic [31:0] ra;
      logic [31:0] ma;

      repeat (3) @(posedge clk);
      #1;
      check_outputs_zero("reset");
      reset = 1'b1;
      repeat (2) @(posedge clk);

      // Read of the high PTE; the L2 request must appear the cycle after the pulse.
      set_line(32'h1000, {64'hAAAA_0001, 64'h5555_0001});
      drive(1, 32'h1008, 0, 32'h0, 0, 0);
      @(negedge clk);
      chk("rd_req_next_cycle", 128'({l2_req_valid, l2_req_store}), 128'(2'b10));
      chk("rd_req_addr", 128'(l2_req_addr), 128'(32'h1000));
      wait_idle(100);
      chk("rd_hi_pte", 128'(last_rsp_data), 128'(64'hAAAA_0001));

      // Mark accessed with the write held off by ready for 5 cycles.
      set_line(32'h2000, {64'h0000_0000_DEAD_0081, 64'h0000_0000_0000_0001});
      hold_store = 1;
      drive(0, 32'h0, 1, 32'h2000, 1, 0);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(l2_req_valid && l2_req_store) && n < 60);
      chk("mk_wr_seen", 128'(n < 60), 128'(1));
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold_valid_store", 128'({l2_req_valid, l2_req_store}), 128'(2'b11));
         chk("hold_addr", 128'(l2_req_addr), 128'(32'h2000));
         chk("hold_data", l2_req_data, {64'h0000_0000_DEAD_0081, 64'h0000_0000_0000_0041});
      end
      hold_store = 0;
      wait_idle(100);

      // Mark dirty on a PTE that already has A and D: no write.
      set_line(32'h2000, {64'h0000_0000_0000_00C1, 64'h0000_0000_0000_0041});
      w0 = n_l2_writes;
      drive(0, 32'h0, 1, 32'h2008, 0, 1);
      wait_idle(100);
      chk("mk_no_write", 128'(n_l2_writes - w0), 128'(0));

      // Read and mark in the same cycle: read first, mark not lost.
      drive(1, 32'h1008, 1, 32'h1000, 1, 0);
      wait_idle(150);
      chk("rd_before_mk", 128'(last_mk_cycle > last_rsp_cycle), 128'(1));

      // Reset while a read waits on L2.
      lat_force = 40;
      n = n_l2_reads;
      drive(1, 32'h1000, 0, 32'h0, 0, 0);
      for (int i = 0; i < 50 && n_l2_reads == n; i++) @(posedge clk);
      chk("rst_rd_issued", 128'(n_l2_reads - n), 128'(1));
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      check_outputs_zero("midrst");
      exp_rd_q.delete();
      exp_mk_q.delete();
      exp_wr_q.delete();
      lat_force = 0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      drive(1, 32'h1008, 0, 32'h0, 0, 0);
      wait_idle(150);
      chk("post_rst_rd", 128'(last_rsp_data), 128'(ref_get(32'h1008)));

`ifdef PTW_PTE_FWD_EN
      // Forwarding: a read of the just-written line never reaches L2.
      set_line(32'h3000, {64'h0, 64'h1});
      drive(0, 32'h0, 1, 32'h3000, 0, 1);
      wait_idle(100);
      n = n_l2_reads;
      drive(1, 32'h3000, 0, 32'h0, 0, 0);
      wait_idle(100);
      chk("fwd_no_l2_read", 128'(n_l2_reads - n), 128'(0));
      chk("fwd_ad_bits", 128'(last_rsp_data[7:6]), 128'(2'b11));
`endif

      // Randomized mix over a small pool of lines.
      for (int i = 0; i < 8; i++) begin
         set_line(32'h4000 + 32'(i * 16), {$urandom(), $urandom(), $urandom(), $urandom()});
      end
      for (int it = 0; it < 60; it++) begin
         int op;
         op = $urandom_range(0, 2);
         ra = 32'h4000 + 32'($urandom_range(0, 7) << 4) + 32'($urandom_range(0, 1) << 3);
         ma = 32'h4000 + 32'($urandom_range(0, 7) << 4) + 32'($urandom_range(0, 1) << 3);
         drive(op != 1, ra, op != 0, ma, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         wait_idle(200);
      end

      chk("end_rd_q_empty", 128'(exp_rd_q.size()), 128'(0));
      chk("end_mk_q_empty", 128'(exp_mk_q.size()), 128'(0));
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation still running at %0t, expected completion", $time);
      $display("%0d/%0d checks passed", n_pass, n_checks + 1);
      $fatal(1, "timeout");
   end

endmodule
